ps2_key_decoder: RTL and testbench

Converts the byte stream from the PS/2 keyboard receiver into four level-held key gates (`key0`..`key3`) that drive the arpeggiator and the voice path. It tracks make, break (`F0`) and extended (`E0`) prefixes. It maps four configurable scan codes to key bits and ignores everything else. A prefix timeout and a keyboard-reset code keep notes from sticking.

---
 rtl/synth_pkg.sv | 15 +
 rtl/ps2_key_map.sv | 17 +
 rtl/ps2_key_decoder.sv | 96 +++++++++
 tb/tb_ps2_key_decoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and PS/2 protocol constants for the synth key front end.
package synth_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } kd_state_t;

   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;

endpackage

// File: rtl/ps2_key_map.sv
// Combinational scan-code lookup; duplicate codes light every matching bit.
module ps2_key_map #(
   parameter logic [7:0] KEY0_CODE = 8'h1C,
   parameter logic [7:0] KEY1_CODE = 8'h1B,
   parameter logic [7:0] KEY2_CODE = 8'h23,
   parameter logic [7:0] KEY3_CODE = 8'h2B
) (
   input  logic [7:0] code_i,
   output logic [3:0] match_o
);

   assign match_o = {(code_i == KEY3_CODE),
                     (code_i == KEY2_CODE),
                     (code_i == KEY1_CODE),
                     (code_i == KEY0_CODE)};

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 byte stream to four held key gates, with make/break/extended tracking,
// BAT-code clear and a prefix timeout so notes never stick.
module ps2_key_decoder
   import synth_pkg::*;
#(
   parameter logic [7:0]  KEY0_CODE      = 8'h1C,
   parameter logic [7:0]  KEY1_CODE      = 8'h1B,
   parameter logic [7:0]  KEY2_CODE      = 8'h23,
   parameter logic [7:0]  KEY3_CODE      = 8'h2B,
   parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] code,
   input  logic       code_valid,
   output logic       key0,
   output logic       key1,
   output logic       key2,
   output logic       key3,
   output logic       key_event
);

   kd_state_t   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  keys_q, keys_d;
   logic [3:0]  keys_prev_q;
   logic [3:0]  match;

   ps2_key_map #(
      .KEY0_CODE (KEY0_CODE),
      .KEY1_CODE (KEY1_CODE),
      .KEY2_CODE (KEY2_CODE),
      .KEY3_CODE (KEY3_CODE)
   ) u_map (
      .code_i  (code),
      .match_o (match)
   );

   always_comb begin
      state_d = state_q;
      keys_d  = keys_q;
      cnt_d   = cnt_q;
      if (code_valid) begin
         cnt_d = '0;
         unique case (state_q)
            IDLE: begin
               if (code == PS2_BREAK)       state_d = BRK;
               else if (code == PS2_EXT)    state_d = EXT;
               else if (code == PS2_BAT_OK) keys_d  = '0;
               else                         keys_d  = keys_q | match;
            end
            BRK: begin
               keys_d  = keys_q & ~match;
               state_d = IDLE;
            end
            EXT: begin
               // Extended makes are swallowed so E0-prefixed keys never alias.
               state_d = (code == PS2_BREAK) ? EXT_BRK : IDLE;
            end
            EXT_BRK: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         // Fire on the idle cycle that would bring the count to the limit.
         if ((PREFIX_TIMEOUT != 16'd0) && (cnt_q == PREFIX_TIMEOUT - 16'd1)) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         keys_q      <= '0;
         keys_prev_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         keys_q      <= keys_d;
         keys_prev_q <= keys_q;
      end
   end

   assign key0      = keys_q[0];
   assign key1      = keys_q[1];
   assign key2      = keys_q[2];
   assign key3      = keys_q[3];
   assign key_event = (keys_q != keys_prev_q);

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed vector bench for ps2_key_decoder (PREFIX_TIMEOUT = 10).
module tb_ps2_key_decoder;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] code;
   logic       code_valid;
   logic       key0, key1, key2, key3, key_event;

   int checks = 0;
   int errors = 0;

   ps2_key_decoder #(.PREFIX_TIMEOUT(16'd10)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .code       (code),
      .code_valid (code_valid),
      .key0       (key0),
      .key1       (key1),
      .key2       (key2),
      .key3       (key3),
      .key_event  (key_event)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       v;
      logic [7:0] c;
      logic [3:0] keys;
      logic       ev;
      string      name;
   } vec_t;

   vec_t vecs[$];

   task automatic step(input logic v, input logic [7:0] c);
      code_valid = v;
      code       = c;
      @(posedge CLK);
      #1;
      code_valid = 1'b0;
      code       = 8'h00;
   endtask

   task automatic check(input string name, input logic [3:0] keys, input logic ev);
      logic [4:0] act, exp;
      act = {key3, key2, key1, key0, key_event};
      exp = {keys, ev};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got keys=%b ev=%b, expected keys=%b ev=%b",
                  name, act[4:1], act[0], exp[4:1], exp[0]);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   initial begin
      // make/break
      vecs.push_back('{1'b1, 8'h1C, 4'b0001, 1'b1, "make_1C"});
      vecs.push_back('{1'b0, 8'h00, 4'b0001, 1'b0, "hold_1C"});
      vecs.push_back('{1'b1, 8'hF0, 4'b0001, 1'b0, "brk_prefix"});
      vecs.push_back('{1'b1, 8'h1C, 4'b0000, 1'b1, "break_1C"});
      vecs.push_back('{1'b0, 8'h00, 4'b0000, 1'b0, "after_break"});
      // extended then typematic
      vecs.push_back('{1'b1, 8'hE0, 4'b0000, 1'b0, "ext_prefix"});
      vecs.push_back('{1'b1, 8'h1C, 4'b0000, 1'b0, "ext_1C_ignored"});
      vecs.push_back('{1'b1, 8'h1C, 4'b0001, 1'b1, "make_after_ext"});
      vecs.push_back('{1'b1, 8'h1C, 4'b0001, 1'b0, "repeat1"});
      vecs.push_back('{1'b1, 8'h1C, 4'b0001, 1'b0, "repeat2"});
      // chord and BAT
      vecs.push_back('{1'b1, 8'h1B, 4'b0011, 1'b1, "make_1B"});
      vecs.push_back('{1'b1, 8'h23, 4'b0111, 1'b1, "make_23"});
      vecs.push_back('{1'b1, 8'h2B, 4'b1111, 1'b1, "make_2B"});
      vecs.push_back('{1'b1, 8'hAA, 4'b0000, 1'b1, "bat_clear"});
      vecs.push_back('{1'b0, 8'h00, 4'b0000, 1'b0, "after_bat"});
      vecs.push_back('{1'b1, 8'hF0, 4'b0000, 1'b0, "stray_prefix"});
      vecs.push_back('{1'b1, 8'h1B, 4'b0000, 1'b0, "stray_break"});
      // extended break leaves held key alone
      vecs.push_back('{1'b1, 8'h1C, 4'b0001, 1'b1, "make_1C_b"});
      vecs.push_back('{1'b1, 8'hE0, 4'b0001, 1'b0, "ext_prefix_b"});
      vecs.push_back('{1'b1, 8'hF0, 4'b0001, 1'b0, "ext_brk_prefix"});
      vecs.push_back('{1'b1, 8'h1C, 4'b0001, 1'b0, "ext_break_ignored"});
      vecs.push_back('{1'b1, 8'h1C, 4'b0001, 1'b0, "back_in_idle"});
      // back-to-back break while key3 held
      vecs.push_back('{1'b1, 8'h2B, 4'b1001, 1'b1, "make_2B_b"});
      vecs.push_back('{1'b1, 8'hF0, 4'b1001, 1'b0, "b2b_prefix"});
      vecs.push_back('{1'b1, 8'h2B, 4'b0001, 1'b1, "b2b_break_2B"});
      vecs.push_back('{1'b1, 8'hF0, 4'b0001, 1'b0, "b2b_prefix2"});
      vecs.push_back('{1'b1, 8'h1C, 4'b0000, 1'b1, "b2b_break_1C"});
      // unmapped codes
      vecs.push_back('{1'b1, 8'h55, 4'b0000, 1'b0, "unmapped_make"});
      vecs.push_back('{1'b1, 8'hF0, 4'b0000, 1'b0, "unmapped_prefix"});
      vecs.push_back('{1'b1, 8'h55, 4'b0000, 1'b0, "unmapped_break"});
      vecs.push_back('{1'b1, 8'h1C, 4'b0001, 1'b1, "make_after_unmapped"});

      // reset state, with code_valid ignored during reset
      RESET = 1'b1;
      code_valid = 1'b1;
      code = 8'h1C;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      check("reset_state", 4'b0000, 1'b0);
      RESET = 1'b0;
      code_valid = 1'b0;
      code = 8'h00;
      step(1'b0, 8'h00);
      check("post_reset_idle", 4'b0000, 1'b0);

      foreach (vecs[i]) begin
         step(vecs[i].v, vecs[i].c);
         check(vecs[i].name, vecs[i].keys, vecs[i].ev);
      end

      // clear key0, then prefix timeout after 10 idle cycles
      step(1'b1, 8'hF0);
      step(1'b1, 8'h1C);
      check("pre_timeout_clear", 4'b0000, 1'b1);
      step(1'b1, 8'hF0);
      idle(10);
      check("timeout_idle_keys", 4'b0000, 1'b0);
      step(1'b1, 8'h1C);
      check("timeout_then_make", 4'b0001, 1'b1);

      // byte arrives on the 10th cycle, before timeout fires
      step(1'b1, 8'hF0);
      idle(9);
      step(1'b1, 8'h1C);
      check("byte_beats_timeout", 4'b0000, 1'b1);

      // reset mid-prefix
      step(1'b1, 8'h23);
      check("hold_key2", 4'b0100, 1'b1);
      step(1'b1, 8'hF0);
      RESET = 1'b1;
      step(1'b0, 8'h00);
      RESET = 1'b0;
      check("reset_mid_prefix", 4'b0000, 1'b0);
      step(1'b1, 8'h23);
      check("make_after_reset", 4'b0100, 1'b1);
      step(1'b0, 8'h00);
      check("event_one_cycle", 4'b0100, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
